// File: rtl/hls_macc_ctrl_master.sv
// ap_ctrl_hs initiator for hls_macc_0_obf: takes one job, runs the core, returns captured outputs.
// Optional HLS_MACC_CTRL_PERF_EN adds perf_jobs / perf_last_lat counters.
module hls_macc_ctrl_master #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] OUT30_INIT     = 32'd0
) (
  input  logic         ap_clk,
  input  logic         ap_rst,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [639:0] job_operands,
  input  logic         seed_valid,
  input  logic [31:0]  seed_data,
  output logic [639:0] core_operands,
  output logic         core_ap_start,
  input  logic         core_ap_done,
  input  logic         core_ap_idle,
  input  logic         core_ap_ready,
  input  logic [31:0]  core_out13,
  input  logic         core_out13_vld,
  output logic [31:0]  core_out30_i,
  input  logic [31:0]  core_out30_o,
  input  logic         core_out30_vld,
  input  logic [31:0]  core_out31,
  input  logic         core_out31_vld,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [31:0]  res_out13,
  output logic [31:0]  res_out30,
  output logic [31:0]  res_out31,
  output logic [3:0]   res_status,
  output logic         busy
`ifdef HLS_MACC_CTRL_PERF_EN
  ,
  output logic [31:0]  perf_jobs,
  output logic [15:0]  perf_last_lat
`endif
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_START = 4'b0010,
    S_WAIT  = 4'b0100,
    S_RESP  = 4'b1000
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t         r_state;
  state_t         w_next;
  logic [15:0]    r_cnt;
  logic [31:0]    r_shadow;
  logic [639:0]   r_ops;
  logic [31:0]    r_out13;
  logic [31:0]    r_out30;
  logic [31:0]    r_out31;
  logic [3:0]     r_status;
  logic           w_active;
  logic           w_accept;
  logic           w_done_evt;
  logic           w_timeout;

  assign w_active = (r_state == S_START) || (r_state == S_WAIT);
  assign w_accept = (r_state == S_IDLE) && job_valid && core_ap_idle;
  // In START, completion only counts once the core has also taken the start.
  assign w_done_evt = (r_state == S_START) ? (core_ap_ready && core_ap_done)
                                           : ((r_state == S_WAIT) && core_ap_done);
  assign w_timeout = w_active && (r_cnt == TO_LAST) && !w_done_evt;

  always_comb begin
    w_next        = r_state;
    job_ready     = 1'b0;
    core_ap_start = 1'b0;
    res_valid     = 1'b0;
    case (r_state)
      S_IDLE: begin
        job_ready = core_ap_idle;
        if (w_accept) w_next = S_START;
      end
      S_START: begin
        core_ap_start = 1'b1;
        if (w_timeout)          w_next = S_RESP;
        else if (core_ap_ready) w_next = core_ap_done ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (w_timeout || core_ap_done) w_next = S_RESP;
      end
      S_RESP: begin
        res_valid = 1'b1;
        if (res_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_shadow <= OUT30_INIT;
      r_ops    <= '0;
      r_out13  <= '0;
      r_out30  <= '0;
      r_out31  <= '0;
      r_status <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_ops    <= job_operands;
        r_status <= '0;
        r_cnt    <= '0;
      end else if (w_active) begin
        r_cnt <= r_cnt + 16'd1;
      end
      if ((r_state == S_IDLE) && seed_valid)  r_shadow <= seed_data;
      else if (w_active && core_out30_vld)    r_shadow <= core_out30_o;
      if (w_active) begin
        if (core_out13_vld) begin r_out13 <= core_out13;   r_status[0] <= 1'b1; end
        if (core_out30_vld) begin r_out30 <= core_out30_o; r_status[1] <= 1'b1; end
        if (core_out31_vld) begin r_out31 <= core_out31;   r_status[2] <= 1'b1; end
        if (w_timeout) r_status[3] <= 1'b1;
      end
    end
  end

  assign core_operands = r_ops;
  assign core_out30_i  = r_shadow;
  assign res_out13     = r_out13;
  assign res_out30     = r_out30;
  assign res_out31     = r_out31;
  assign res_status    = r_status;
  assign busy          = (r_state != S_IDLE);

`ifdef HLS_MACC_CTRL_PERF_EN
  logic [31:0] r_perf_jobs;
  logic [15:0] r_perf_lat;

  // r_cnt never exceeds TIMEOUT_CYCLES-1 <= 16'hFFFE, so the latency saturates by construction.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_perf_jobs <= '0;
      r_perf_lat  <= '0;
    end else begin
      if ((r_state == S_RESP) && res_ready) r_perf_jobs <= r_perf_jobs + 32'd1;
      if (w_done_evt) r_perf_lat <= r_cnt;
    end
  end

  assign perf_jobs     = r_perf_jobs;
  assign perf_last_lat = r_perf_lat;
`endif

endmodule

// File: tb/tb_hls_macc_ctrl_master.sv
// Randomized self-checking bench for hls_macc_ctrl_master with a stub core and a job-level model.
module tb_hls_macc_ctrl_master;

  localparam int          TO   = 8;
  localparam logic [31:0] INIT = 32'h0000_00A5;

  logic         clk;
  logic         ap_rst;
  logic         job_valid;
  logic         job_ready;
  logic [639:0] job_operands;
  logic         seed_valid;
  logic [31:0]  seed_data;
  logic [639:0] core_operands;
  logic         core_ap_start;
  logic         core_ap_done;
  logic         core_ap_idle;
  logic         core_ap_ready;
  logic [31:0]  core_out13;
  logic         core_out13_vld;
  logic [31:0]  core_out30_i;
  logic [31:0]  core_out30_o;
  logic         core_out30_vld;
  logic [31:0]  core_out31;
  logic         core_out31_vld;
  logic         res_valid;
  logic         res_ready;
  logic [31:0]  res_out13;
  logic [31:0]  res_out30;
  logic [31:0]  res_out31;
  logic [3:0]   res_status;
  logic         busy;
`ifdef HLS_MACC_CTRL_PERF_EN
  logic [31:0]  perf_jobs;
  logic [15:0]  perf_last_lat;
`endif

  hls_macc_ctrl_master #(.TIMEOUT_CYCLES(TO), .OUT30_INIT(INIT)) dut (
    .ap_clk(clk), .ap_rst(ap_rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_operands(job_operands),
    .seed_valid(seed_valid), .seed_data(seed_data),
    .core_operands(core_operands), .core_ap_start(core_ap_start),
    .core_ap_done(core_ap_done), .core_ap_idle(core_ap_idle), .core_ap_ready(core_ap_ready),
    .core_out13(core_out13), .core_out13_vld(core_out13_vld),
    .core_out30_i(core_out30_i), .core_out30_o(core_out30_o), .core_out30_vld(core_out30_vld),
    .core_out31(core_out31), .core_out31_vld(core_out31_vld),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_out13(res_out13), .res_out30(res_out30), .res_out31(res_out31),
    .res_status(res_status), .busy(busy)
`ifdef HLS_MACC_CTRL_PERF_EN
    , .perf_jobs(perf_jobs), .perf_last_lat(perf_last_lat)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  // Reference model: what the job-level contract says the block holds.
  logic [31:0]  m_shadow;
  logic [31:0]  m_r13, m_r30, m_r31;
  logic [3:0]   m_st;
  logic [639:0] m_ops;
  logic [31:0]  m_jobs;
  logic [15:0]  m_lat;

  task automatic chk(input string tag, input logic [639:0] got, input logic [639:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_shadow = INIT; m_r13 = '0; m_r30 = '0; m_r31 = '0;
    m_st = '0; m_ops = '0; m_jobs = '0; m_lat = '0;
  endtask

  task automatic set_strobes(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c, input bit live);
    core_out13_vld = m[0]; core_out13   = a;
    core_out30_vld = m[1]; core_out30_o = b;
    core_out31_vld = m[2]; core_out31   = c;
    if (live) begin
      if (m[0]) begin m_r13 = a; m_st[0] = 1'b1; end
      if (m[1]) begin m_r30 = b; m_st[1] = 1'b1; m_shadow = b; end
      if (m[2]) begin m_r31 = c; m_st[2] = 1'b1; end
    end
  endtask

  task automatic check_fields(input string tag);
    chk({tag, ".out13"},  res_out13,  m_r13);
    chk({tag, ".out30"},  res_out30,  m_r30);
    chk({tag, ".out31"},  res_out31,  m_r31);
    chk({tag, ".status"}, res_status, m_st);
  endtask

  task automatic check_perf();
`ifdef HLS_MACC_CTRL_PERF_EN
    chk("perf_jobs", perf_jobs, m_jobs);
    chk("perf_last_lat", perf_last_lat, m_lat);
`endif
  endtask

  // d: cycle of the done strobe set (or of dm strobes in timeout mode), r: ap_ready cycle.
  task automatic run_job(input int d, input int r, input bit to, input logic [2:0] dm,
                         input logic [31:0] v13, input logic [31:0] v30, input logic [31:0] v31,
                         input bit noise, input int hold, input bit seed_en, input logic [31:0] seed_val);
    logic [639:0] ops;
    int k;
    int end_k;
    for (int i = 0; i < 20; i++) ops[i*32 +: 32] = $urandom();
    if (noise && $urandom_range(3, 0) == 0) begin
      core_ap_idle = 1'b0; job_valid = 1'b1; job_operands = ~ops;
      #1;
      chk("job_ready_core_busy", job_ready, 1'b0);
      @(negedge clk);
      chk("no_accept_core_busy", busy, 1'b0);
    end
    core_ap_idle = 1'b1; job_valid = 1'b1; job_operands = ops;
    seed_valid = seed_en; seed_data = seed_val;
    if (noise) set_strobes(3'($urandom_range(7, 0)), $urandom(), $urandom(), $urandom(), 1'b0);
    else       set_strobes(3'b000, '0, '0, '0, 1'b0);
    #1;
    chk("job_ready_idle", job_ready, 1'b1);
    if (seed_en) m_shadow = seed_val;
    m_ops = ops;
    m_st  = '0;
    @(negedge clk);
    job_valid = 1'b0; job_operands = ~ops; core_ap_idle = 1'b0; seed_valid = 1'b0;
    end_k = to ? TO : d + 1;
    k = 0;
    while (!res_valid && k < 40) begin
      chk("busy_active", busy, 1'b1);
      chk("ap_start", core_ap_start, (k <= r));
      chk("out30_i_active", core_out30_i, m_shadow);
      if (k == 0) chk("operands", core_operands, m_ops);
      core_ap_ready = (k == r);
      core_ap_done  = !to && (k == d);
      seed_valid    = $urandom_range(1, 0) == 1;
      seed_data     = $urandom();
      if (k == d)     set_strobes(dm, v13, v30, v31, 1'b1);
      else if (noise) set_strobes(3'($urandom_range(7, 0)) & 3'($urandom_range(7, 0)),
                                  $urandom(), $urandom(), $urandom(), 1'b1);
      else            set_strobes(3'b000, '0, '0, '0, 1'b0);
      @(negedge clk);
      k++;
    end
    chk("resp_cycle", k, end_k);
    core_ap_ready = 1'b0; core_ap_done = 1'b0; core_ap_idle = 1'b1; seed_valid = 1'b0;
    if (to) m_st[3] = 1'b1;
    else    m_lat = 16'(d);
    res_ready = 1'b0; job_valid = 1'b1;
    for (int h = 0; h <= hold; h++) begin
      if (noise) begin
        set_strobes(3'($urandom_range(7, 0)), $urandom(), $urandom(), $urandom(), 1'b0);
        seed_valid = $urandom_range(1, 0) == 1;
        seed_data  = $urandom();
      end else begin
        set_strobes(3'b000, '0, '0, '0, 1'b0);
      end
      res_ready = (h == hold);
      #1;
      chk("res_valid", res_valid, 1'b1);
      chk("job_ready_resp", job_ready, 1'b0);
      chk("ap_start_resp", core_ap_start, 1'b0);
      chk("out30_i_resp", core_out30_i, m_shadow);
      check_fields("resp");
      @(negedge clk);
    end
    m_jobs++;
    res_ready = 1'b0; job_valid = 1'b0; seed_valid = 1'b0;
    set_strobes(3'b000, '0, '0, '0, 1'b0);
    chk("res_valid_drop", res_valid, 1'b0);
    chk("busy_after", busy, 1'b0);
    chk("operands_after", core_operands, m_ops);
    check_fields("after");
    check_perf();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int  d, r;
  bit  to;

  initial begin
    ap_rst = 1'b1; job_valid = 1'b0; job_operands = '0; seed_valid = 1'b0; seed_data = '0;
    core_ap_done = 1'b0; core_ap_idle = 1'b1; core_ap_ready = 1'b0; res_ready = 1'b0;
    set_strobes(3'b000, '0, '0, '0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    ap_rst = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_ap_start", core_ap_start, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_out30_i", core_out30_i, INIT);
    chk("rst_operands", core_operands, '0);
    chk("rst_job_ready", job_ready, 1'b1);
    check_fields("rst");
    check_perf();
    @(negedge clk);

    // Basic job, then backpressure, timeout and seeded job.
    run_job(3, 3, 1'b0, 3'b111, 32'd70, 32'd5, 32'd9, 1'b0, 0, 1'b0, '0);
    chk("shadow_after_basic", core_out30_i, 32'd5);
    run_job(2, 1, 1'b0, 3'b110, 32'h0, 32'h77, 32'h88, 1'b0, 10, 1'b0, '0);
    run_job(2, 0, 1'b1, 3'b001, 32'h1234, 32'h0, 32'h0, 1'b0, 1, 1'b0, '0);
    chk("timeout_status", res_status, 4'b1001);
    run_job(4, 2, 1'b0, 3'b101, 32'h11, 32'h0, 32'h33, 1'b0, 0, 1'b1, 32'hDEADBEEF);
    chk("seed_kept", core_out30_i, 32'hDEADBEEF);
    chk("seed_status1", res_status[1], 1'b0);

    // Reset while waiting on the core.
    core_ap_idle = 1'b1; job_valid = 1'b1; job_operands = {20{32'h1111_2222}};
    @(negedge clk);
    job_valid = 1'b0; core_ap_idle = 1'b0; core_ap_ready = 1'b1;
    @(negedge clk);
    core_ap_ready = 1'b0;
    set_strobes(3'b111, 32'd1, 32'd2, 32'd3, 1'b0);
    @(negedge clk);
    set_strobes(3'b000, '0, '0, '0, 1'b0);
    chk("wait_busy", busy, 1'b1);
    ap_rst = 1'b1;
    @(negedge clk);
    ap_rst = 1'b0;
    model_reset();
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ap_start", core_ap_start, 1'b0);
    chk("midrst_res_valid", res_valid, 1'b0);
    chk("midrst_out30_i", core_out30_i, INIT);
    chk("midrst_operands", core_operands, '0);
    check_fields("midrst");
    check_perf();
    @(negedge clk);
    run_job(4, 4, 1'b0, 3'b111, 32'd1, 32'd2, 32'd3, 1'b0, 0, 1'b0, '0);
    run_job(4, 1, 1'b0, 3'b011, 32'd4, 32'd5, 32'd6, 1'b0, 0, 1'b0, '0);
    run_job(6, 3, 1'b0, 3'b100, 32'd7, 32'd8, 32'd9, 1'b0, 0, 1'b0, '0);

    for (int j = 0; j < 40; j++) begin
      to = ($urandom_range(4, 0) == 0);
      d  = $urandom_range(TO - 1, 0);
      if (to) r = ($urandom_range(1, 0) == 1) ? 99 : $urandom_range(3, 0);
      else    r = $urandom_range(d, 0);
      run_job(d, r, to, 3'($urandom_range(7, 0)), $urandom(), $urandom(), $urandom(),
              1'b1, $urandom_range(4, 0), $urandom_range(1, 0) == 1, $urandom());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hls_macc_ctrl_master.md
Name: hls_macc_ctrl_master

Overview:
- Initiator side of the ap_ctrl_hs handshake used by the generated hls_macc_0_obf core.
- Accepts one job at a time (20 operands) on a valid/ready command port, then drives the core's inputs and ap_start.
- Captures out13, out30_o and out31 on their ap_vld strobes and returns them on a valid/ready result port.
- Owns the out30 read-modify-write shadow register: it feeds out30_i and is updated from out30_o.
- Sits between the system job scheduler and the core. locking_key is not driven here; it comes from the key distribution logic.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles from ap_start assertion to ap_done before the job aborts; legal range 8..65535.
- OUT30_INIT, 32'd0, reset value of the out30 shadow register.

Ports:
- ap_clk  in  1  clock
- ap_rst  in  1  synchronous active-high reset
- job_valid  in  1  command valid
- job_ready  out  1  command accepted this cycle when both high
- job_operands  in  640  {in32,in29,in28,in27,in24,in22,in20,in19,in17,in15,in12,in14,in10,in9,in8,in7,in4,in3,in2,in1}; in1 in bits [31:0]
- seed_valid  in  1  load out30 shadow; honoured only in IDLE
- seed_data  in  32  value loaded into the shadow
- core_operands  out  640  registered operands to the core, same packing as job_operands
- core_ap_start  out  1  to core ap_start
- core_ap_done  in  1  from core
- core_ap_idle  in  1  from core
- core_ap_ready  in  1  from core
- core_out13  in  32  from core
- core_out13_vld  in  1  from core
- core_out30_i  out  32  shadow value to core out30_i
- core_out30_o  in  32  from core
- core_out30_vld  in  1  from core
- core_out31  in  32  from core
- core_out31_vld  in  1  from core
- res_valid  out  1  result valid
- res_ready  in  1  result consumed when both high
- res_out13  out  32  captured out13
- res_out30  out  32  captured out30_o
- res_out31  out  32  captured out31
- res_status  out  4  [0] out13 captured, [1] out30 captured, [2] out31 captured, [3] timeout
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clocking and reset: one clock, ap_clk. ap_rst is synchronous and active-high.
- Reset values:
  - state = IDLE; core_ap_start = 0; res_valid = 0.
  - res_out13, res_out30, res_out31 and res_status = 0; core_operands = 0.
  - Shadow = OUT30_INIT; timeout counter = 0.
- The core shares ap_rst. Reset mid-job aborts with no result emitted, and the next job starts clean.
- States are IDLE, START, WAIT and RESP, one-hot encoded.
- IDLE:
  - job_ready = core_ap_idle. It is 0 in all other states.
  - On accept: latch job_operands into core_operands, clear res_status and the counter, and go to START. core_ap_start rises on the next cycle.
  - seed_valid loads the shadow from seed_data. If seed_valid and job accept occur in the same cycle, the seed is loaded first and the job sees the seeded value.
- START:
  - core_ap_start = 1, held until core_ap_ready is sampled 1.
  - If core_ap_done is also 1 that cycle, go to RESP. Otherwise go to WAIT.
  - core_ap_start is registered low in the cycle after ap_ready.
- WAIT:
  - core_ap_start = 0.
  - core_ap_done = 1 → RESP.
- Capture, in START and WAIT, on any cycle:
  - A vld strobe latches its data into the matching res_* field and sets the matching status bit. A later strobe overwrites the earlier value.
  - core_out30_vld also writes core_out30_o into the shadow in the same cycle.
  - Strobes seen in IDLE or RESP are ignored.
- Timeout:
  - The counter increments each cycle in START and WAIT.
  - When it equals TIMEOUT_CYCLES-1 without ap_done: set status[3], drop core_ap_start and go to RESP. Captured fields keep whatever arrived.
- RESP:
  - res_valid = 1. All res_* outputs are stable until res_valid && res_ready.
  - On handshake, go to IDLE. res_* fields keep their values after the handshake; res_valid drops.
- core_out30_i = shadow, continuously.
- core_operands change only on job accept.
- Latency: job accept → core_ap_start is 1 cycle. core_ap_done → res_valid is 1 cycle. A back-to-back job can be accepted no earlier than the cycle after the result handshake.

Optional Feature:
- Macro: HLS_MACC_CTRL_PERF_EN.
- When defined, add outputs perf_jobs (32-bit) and perf_last_lat (16-bit):
  - perf_jobs counts completed result handshakes, including timeouts, and wraps at 2^32.
  - perf_last_lat holds the START-entry-to-ap_done cycle count of the last non-timeout job, saturating at 16'hFFFF.
  - Both reset to 0.
- When undefined, these ports and counters are absent and all other behaviour is identical.

Test Plan:
- Basic job: stub core responds with ap_ready/ap_done 3 cycles after ap_start, out13=70, out30_o=5, out31=9, all vld in the done cycle → res_valid 1 cycle later with res_out13=70, res_out30=5, res_out31=9, status=4'b0111; shadow becomes 5 and core_out30_i=5.
- Backpressure: hold res_ready=0 for 10 cycles, drive job_valid=1 → res_* stable, job_ready=0 throughout; the second job is accepted the cycle after res_ready=1.
- Timeout with TIMEOUT_CYCLES=8: stub never asserts ap_done, asserts only out13_vld with 0x1234 → RESP after 8 cycles, status=4'b1001, res_out13=0x1234, core_ap_start low.
- Seed: seed_valid=1, seed_data=0xDEADBEEF in IDLE together with a job, stub emits no out30_vld → core_out30_i=0xDEADBEEF during the job, status[1]=0; seed_valid pulsed in WAIT → ignored.
- Reset mid-WAIT: assert ap_rst for 1 cycle → state IDLE, core_ap_start=0, res_valid=0, shadow=OUT30_INIT; a new job then completes normally.
- Perf build with HLS_MACC_CTRL_PERF_EN defined: 3 jobs, latencies 4/4/6 → perf_jobs=3, perf_last_lat=6.
